// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and types for the seven-segment scan controller.
//   SEG_BLANK    : active-low segment pattern with every segment off
//   HEX_SEG      : active-low hex glyphs, index = nibble, bit7 (dp) off
//   scan_state_t : per-digit-slot phase
package sseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Packed so HEX_SEG[n] selects glyph n; the list runs F..0 (MSB first).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hA7, 8'h83, 8'h88, 8'h98, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: registered hex-to-7-segment decoder, active-low outputs.
//   clk     : system clock
//   reset_n : asynchronous active-low reset, output goes to all-off
//   nibble  : hex digit to show
//   dp      : decimal point, 1 = lit
//   seg     : segments, active low, bit7 = dp, bits6:0 = g..a (1-cycle latency)
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= SEG_BLANK;
    end else begin
      seg <= HEX_SEG[nibble] & {~dp, 7'h7F};
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexes NUM_DIGITS hex digits onto one shared
// registered decoder driving common-anode displays.
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   value_in    : nibble i = digit i (digit 0 least significant)
//   dp_in       : decimal point per digit, 1 = lit
//   load        : 1-cycle strobe, capture value_in/dp_in as pending
//   load_ack    : 1-cycle pulse when pending data is committed to display
//   digit_en    : 1 = digit slot may light
//   lz_blank    : 1 = blank leading zeros
//   sseg        : segments, active low, bit7 = dp
//   an          : anode selects, active low
//   frame_start : 1-cycle pulse on entering digit 0's blank phase
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL_CYC  = 100000,
  parameter int unsigned BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    load_ack,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [7:0]              sseg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned CMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_t                 state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        started_q;
  logic                        frame_go;
  logic                        enter_drive;
  logic                        lit_q;
  logic                        lit_next;

  logic [NUM_DIGITS-1:0][3:0]  sh_val, pend_val;
  logic [NUM_DIGITS-1:0]       sh_dp, pend_dp;
  logic                        pend_flag;

  logic [NUM_DIGITS-1:0]       zero_from;
  logic [NUM_DIGITS-1:0]       lz_vec;
  logic                        zacc;
  logic [7:0]                  dec_seg;

  // The first edge after reset is treated as entering digit 0's blank
  // phase: the counter holds at 0 so that edge starts a full-length frame.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    frame_go    = 1'b0;
    enter_drive = 1'b0;
    if (!started_q) begin
      cnt_d    = cnt_q;
      frame_go = 1'b1;
    end else if (state_q == BLANK) begin
      if (cnt_q == CW'(BLANK_CYC - 1)) begin
        state_d     = DRIVE;
        cnt_d       = '0;
        enter_drive = 1'b1;
      end
    end else begin
      if (cnt_q == CW'(DWELL_CYC - 1)) begin
        state_d = BLANK;
        cnt_d   = '0;
        if (idx_q == IW'(NUM_DIGITS - 1)) begin
          idx_d    = '0;
          frame_go = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  // zero_from[i]: shadow nibbles NUM_DIGITS-1 down to i are all zero.
  always_comb begin
    zero_from = '0;
    lz_vec    = '0;
    zacc      = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zacc = zacc & (sh_val[NUM_DIGITS-1-k] == 4'h0);
      zero_from[NUM_DIGITS-1-k] = zacc;
    end
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      lz_vec[i] = lz_blank & ~sh_dp[i] & zero_from[i];
    end
    lit_next = digit_en[idx_q] & ~lz_vec[idx_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      started_q   <= 1'b0;
      lit_q       <= 1'b0;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
      sh_val      <= '0;
      sh_dp       <= '0;
      pend_val    <= '0;
      pend_dp     <= '0;
      pend_flag   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      started_q   <= 1'b1;
      frame_start <= frame_go;
      if (enter_drive) begin
        lit_q <= lit_next;
      end
      // Commit only at the frame boundary; a load landing on that same edge
      // bypasses the pending register.
      if (frame_go) begin
        load_ack  <= load | pend_flag;
        pend_flag <= 1'b0;
        if (load) begin
          sh_val <= value_in;
          sh_dp  <= dp_in;
        end else if (pend_flag) begin
          sh_val <= pend_val;
          sh_dp  <= pend_dp;
        end
      end else begin
        load_ack <= 1'b0;
        if (load) begin
          pend_val  <= value_in;
          pend_dp   <= dp_in;
          pend_flag <= 1'b1;
        end
      end
    end
  end

  // Decoder sees the current slot's digit throughout the slot; since shadow
  // only changes at idx 0 entry and blank lasts >= 2 cycles, sseg is settled
  // before the anode turns on.
  sseg_hex_decode u_dec (
    .clk     (clk),
    .reset_n (reset_n),
    .nibble  (sh_val[idx_q]),
    .dp      (sh_dp[idx_q]),
    .seg     (dec_seg)
  );

  always_comb begin
    an   = '1;
    sseg = dec_seg;
    if (state_q == DRIVE) begin
      if (lit_q) begin
        an[idx_q] = 1'b0;
      end else begin
        sseg = SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BC    = 2;
  localparam int SLOT  = DW + BC;
  localparam int FRAME = N * SLOT;

  logic          clk;
  logic          reset_n;
  logic [15:0]   value_in;
  logic [3:0]    dp_in;
  logic          load;
  logic          load_ack;
  logic [3:0]    digit_en;
  logic          lz_blank;
  logic [7:0]    sseg;
  logic [3:0]    an;
  logic          frame_start;

  int checks;
  int failures;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

  // Reference model: what is on display, and what is waiting to be committed.
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [15:0] p_val;
  logic [3:0]  p_dp;
  bit          p_flag;

  sseg_scan_ctrl #(
    .NUM_DIGITS (N),
    .DWELL_CYC  (DW),
    .BLANK_CYC  (BC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load        (load),
    .load_ack    (load_ack),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .sseg        (sseg),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_lit(int i);
    logic [15:0] upper;
    upper = m_val >> (4 * i);
    if (!digit_en[i]) return 1'b0;
    if (lz_blank && i != 0 && !m_dp[i] && upper == 16'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    p_val    = v;
    p_dp     = d;
    p_flag   = 1'b1;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      n++;
    end while (frame_start !== 1'b1 && n < 3 * FRAME);
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", frame_start, n);
    end
  endtask

  // Samples once per cycle starting at a frame_start sample, checking every
  // output against the model. Up to two loads are injected at sample indices.
  task automatic scan_check(input string tag, input int frames,
                            input int la, input logic [15:0] va, input logic [3:0] da,
                            input int lb, input logic [15:0] vb, input logic [3:0] db);
    int          slot, off;
    bit          exp_ack, lit, drv;
    logic [3:0]  exp_an, nib;
    logic [7:0]  exp_seg;
    for (int t = 0; t < frames * FRAME; t++) begin
      if (t > 0) begin
        @(negedge clk);
        load = 1'b0;
      end
      slot = (t % FRAME) / SLOT;
      off  = t % SLOT;
      exp_ack = 1'b0;
      if (t % FRAME == 0) begin
        exp_ack = p_flag;
        if (p_flag) begin
          m_val  = p_val;
          m_dp   = p_dp;
          p_flag = 1'b0;
        end
      end
      checks++;
      if (frame_start !== (t % FRAME == 0)) begin
        failures++;
        $display("FAIL %s frame_start t=%0d: got %b expected %b", tag, t, frame_start, (t % FRAME == 0));
      end
      checks++;
      if (load_ack !== exp_ack) begin
        failures++;
        $display("FAIL %s load_ack t=%0d: got %b expected %b", tag, t, load_ack, exp_ack);
      end
      lit    = m_lit(slot);
      drv    = (off >= BC);
      exp_an = (drv && lit) ? ~(4'b0001 << slot) : 4'hF;
      checks++;
      if (an !== exp_an) begin
        failures++;
        $display("FAIL %s an t=%0d: got %h expected %h", tag, t, an, exp_an);
      end
      if (drv) begin
        nib     = m_val[4*slot +: 4];
        exp_seg = lit ? (hex_tab[nib] & {~m_dp[slot], 7'h7F}) : 8'hFF;
        checks++;
        if (sseg !== exp_seg) begin
          failures++;
          $display("FAIL %s sseg t=%0d slot=%0d: got %h expected %h", tag, t, slot, sseg, exp_seg);
        end
      end
      if (t == la) drive_load(va, da);
      if (t == lb) drive_load(vb, db);
    end
  endtask

  task automatic model_reset();
    m_val  = '0;
    m_dp   = '0;
    p_val  = '0;
    p_dp   = '0;
    p_flag = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (an !== 4'hF) begin
      failures++;
      $display("FAIL %s an: got %h expected f", tag, an);
    end
    checks++;
    if (sseg !== 8'hFF) begin
      failures++;
      $display("FAIL %s sseg: got %h expected ff", tag, sseg);
    end
    checks++;
    if (load_ack !== 1'b0) begin
      failures++;
      $display("FAIL %s load_ack: got %b expected 0", tag, load_ack);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      failures++;
      $display("FAIL %s frame_start: got %b expected 0", tag, frame_start);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    value_in = '0;
    dp_in    = '0;
    load     = 1'b0;
    digit_en = 4'hF;
    lz_blank = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_frame();
    scan_check("idle", 2, -1, '0, '0, -1, '0, '0);
  endtask

  task automatic test_load_midframe();
    wait_frame();
    scan_check("load_pre", 1, 15, 16'h12AF, 4'h0, -1, '0, '0);
    wait_frame();
    scan_check("load_show", 1, -1, '0, '0, -1, '0, '0);
  endtask

  task automatic test_lz_blank();
    wait_frame();
    scan_check("lz_ld", 1, 3, 16'h0070, 4'h0, -1, '0, '0);
    lz_blank = 1'b1;
    wait_frame();
    scan_check("lz", 1, 3, 16'h0070, 4'b1000, -1, '0, '0);
    wait_frame();
    scan_check("lz_dp", 1, -1, '0, '0, -1, '0, '0);
    lz_blank = 1'b0;
  endtask

  task automatic test_digit_en();
    digit_en = 4'b0101;
    wait_frame();
    scan_check("digit_en", 2, -1, '0, '0, -1, '0, '0);
    digit_en = 4'hF;
  endtask

  task automatic test_back_to_back();
    wait_frame();
    scan_check("b2b_ld", 1, 4, 16'h1111, 4'h0, 22, 16'h2222, 4'h0);
    wait_frame();
    scan_check("b2b_show", 1, FRAME - 1, 16'h5A5A, 4'h5, -1, '0, '0);
    wait_frame();
    scan_check("bypass", 1, -1, '0, '0, -1, '0, '0);
  endtask

  task automatic test_reset_mid_drive();
    wait_frame();
    for (int t = 0; t <= 25; t++) begin
      if (t > 0) begin
        @(negedge clk);
        load = 1'b0;
      end
      if (t == 5) drive_load(16'hBEEF, 4'h3);
    end
    checks++;
    if (an !== 4'hB) begin
      failures++;
      $display("FAIL rst_mid pre an: got %h expected b", an);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    wait_frame();
    scan_check("post_rst", 2, -1, '0, '0, -1, '0, '0);
  endtask

  task automatic test_random();
    int          la, lb;
    logic [15:0] va, vb;
    logic [3:0]  da, db;
    for (int k = 0; k < 8; k++) begin
      digit_en = 4'($urandom_range(0, 15));
      lz_blank = 1'($urandom_range(0, 1));
      la = $urandom_range(0, FRAME - 1);
      lb = ($urandom_range(0, 2) == 0) ? $urandom_range(la, FRAME - 1) : -1;
      va = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      vb = 16'($urandom);
      da = 4'($urandom_range(0, 15));
      db = 4'($urandom_range(0, 15));
      wait_frame();
      scan_check("random", 1, la, va, da, lb, vb, db);
    end
    wait_frame();
    scan_check("random_tail", 1, -1, '0, '0, -1, '0, '0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_load_midframe();
    test_lz_blank();
    test_digit_en();
    test_back_to_back();
    test_reset_mid_drive();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
